// File: rtl/multicore_mem_arbiter_pkg.sv
// Shared types and helpers for the multicore memory arbiter slice.
package mc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N_CORES_DEFAULT = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(N_CORES_DEFAULT);

  // Low bit of a core's field inside a flattened per-core bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/multicore_mem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester above the pointer wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Shares one data memory between N cores and sequences start/done runs.
module multicore_mem_arbiter
  import mc_pkg::*;
#(
  parameter int N_CORES    = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [N_CORES-1:0]            i_core_mask,
  output logic [N_CORES-1:0]            o_core_start,
  input  logic [N_CORES-1:0]            i_core_done,
  output logic                          o_ready,
  output logic                          o_all_done,
  input  logic [N_CORES-1:0]            i_core_req,
  input  logic [N_CORES-1:0]            i_core_we,
  input  logic [N_CORES*ADDR_WIDTH-1:0] i_core_addr,
  input  logic [N_CORES*DATA_WIDTH-1:0] i_core_wdata,
  output logic [N_CORES-1:0]            o_core_ack,
  output logic [DATA_WIDTH-1:0]         o_core_rdata,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata,
  output logic                          o_mem_we,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata
);

  localparam int PTR_W = idx_width(N_CORES);

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [N_CORES-1:0] r_ack;
  logic [N_CORES-1:0] r_mask;
  logic [N_CORES-1:0] r_done_seen;
  logic [N_CORES-1:0] r_core_start;
  logic               r_all_done;
  logic               r_ready;

  logic [N_CORES-1:0] w_elig;
  logic [N_CORES-1:0] w_grant;
  logic [PTR_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_issue;
  logic [N_CORES-1:0] w_done_q;
  logic [N_CORES-1:0] w_done_all;

  // A core acked last cycle is still holding the request it just finished.
  assign w_elig = i_core_req & ~r_ack;

  rr_arbiter #(
    .N     (N_CORES),
    .IDX_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_issue      = w_valid & ~i_rst;
  assign o_mem_we     = w_issue & i_core_we[w_idx];
  assign o_mem_addr   = w_issue ? i_core_addr[slice_lo(int'(w_idx), ADDR_WIDTH) +: ADDR_WIDTH] : '0;
  assign o_mem_wdata  = w_issue ? i_core_wdata[slice_lo(int'(w_idx), DATA_WIDTH) +: DATA_WIDTH] : '0;
  assign o_core_rdata = i_mem_rdata;
  assign o_core_ack   = r_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr <= PTR_W'(N_CORES - 1);
      r_ack    <= '0;
    end else begin
      r_ack <= w_valid ? w_grant : '0;
      if (w_valid) begin
        r_rr_ptr <= w_idx;
      end
    end
  end

  assign w_done_q   = i_core_done & r_mask;
  assign w_done_all = r_done_seen | w_done_q;

  // The first RUN cycle carries core_start, so done seen there is ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_core_start <= '0;
      r_all_done   <= 1'b0;
      r_mask       <= '0;
      r_done_seen  <= '0;
    end else begin
      r_core_start <= '0;
      r_all_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_ready <= 1'b0;
            if (|i_core_mask) begin
              r_mask       <= i_core_mask;
              r_core_start <= i_core_mask;
              r_done_seen  <= '0;
              r_state      <= RUN;
            end else begin
              r_all_done <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        RUN: begin
          if (r_core_start == '0) begin
            r_done_seen <= w_done_all;
            if ((w_done_all == r_mask) && (r_ack == '0)) begin
              r_all_done <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_core_start = r_core_start;
  assign o_all_done   = r_all_done;
  assign o_ready      = r_ready;

endmodule
